// File: rtl/nibble_add_sequencer.sv
// nibble_add_sequencer
//   Adds two NIBBLES*4-bit operands through one external combinational 4-bit
//   adder, one nibble per clock, least-significant nibble first. The carry is
//   chained between nibbles. The full-width result is presented with a
//   one-cycle done pulse.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     request a new addition; ignored while busy
//   a, b, cin operands and carry-in, sampled on the accepting edge
//   busy      high from acceptance through the done cycle
//   done      one-cycle pulse; sum/cout valid
//   sum, cout registered result, held until the next accepted start
//   add_a/add_b/add_cin   drive the external adder (zero when not running)
//   add_sum/add_cout      returned by the external adder
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; adder inputs forced to zero
// RUN   | presenting nibble r_idx to the adder, capturing its result
// DONE  | one-cycle result-valid pulse, then back to IDLE

module nibble_add_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout
);

    localparam int W  = 4 * NIBBLES;
    // A one-nibble build still needs a 1-bit index register.
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;
    logic            r_carry;
    logic            r_cout;
    logic [IW-1:0]   r_idx;
    logic [3:0]      w_a_nib;
    logic [3:0]      w_b_nib;
    logic            w_last;

    assign w_last = (r_idx == LAST_IDX);
    assign sum    = r_sum;
    assign cout   = r_cout;

    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == IW'(i)) begin
                w_a_nib = r_a[4*i +: 4];
                w_b_nib = r_b[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        add_a        = '0;
        add_b        = '0;
        add_cin      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                busy    = 1'b1;
                add_a   = w_a_nib;
                add_b   = w_b_nib;
                add_cin = r_carry;
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (r_idx == IW'(i)) begin
                            r_sum[4*i +: 4] <= add_sum;
                        end
                    end
                    r_carry <= add_cout;
                    // The top carry leaves through cout only; it never wraps into nibble 0.
                    if (w_last) begin
                        r_cout <= add_cout;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_add_sequencer.sv
module tb_nibble_add_sequencer;

    logic        clk;
    logic        rst;

    logic        start4, cin4, busy4, done4, cout4, add_cin4, add_cout4;
    logic [15:0] a4, b4, sum4;
    logic [3:0]  add_a4, add_b4, add_sum4;

    logic        start2, cin2, busy2, done2, cout2, add_cin2, add_cout2;
    logic [7:0]  a2, b2, sum2;
    logic [3:0]  add_a2, add_b2, add_sum2;

    int n_cmp;
    int n_err;

    nibble_add_sequencer #(.NIBBLES(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
        .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
        .add_sum(add_sum4), .add_cout(add_cout4)
    );

    nibble_add_sequencer #(.NIBBLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2),
        .add_a(add_a2), .add_b(add_b2), .add_cin(add_cin2),
        .add_sum(add_sum2), .add_cout(add_cout2)
    );

    // Behavioural stand-in for the 4-bit ripple-carry adder.
    assign {add_cout4, add_sum4} = {1'b0, add_a4} + {1'b0, add_b4} + {4'b0, add_cin4};
    assign {add_cout2, add_sum2} = {1'b0, add_a2} + {1'b0, add_b2} + {4'b0, add_cin2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start an add on the 4-nibble DUT and wait (bounded) for done.
    // lat counts cycles after the accepting edge; traces record what was
    // presented to the adder in each RUN cycle.
    task automatic go4(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                       output int lat, output logic [15:0] tr_a, output logic [3:0] tr_cin);
        @(negedge clk);
        a4 = ia; b4 = ib; cin4 = ic; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        a4 = ~ia; b4 = ~ib; cin4 = ~ic;
        tr_a = '0; tr_cin = '0;
        lat = 1;
        while (!done4 && lat < 20) begin
            if (lat <= 4) begin
                tr_a[4*(lat-1) +: 4] = add_a4;
                tr_cin[lat-1] = add_cin4;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int          lat;
        int          n_done;
        logic [15:0] tr_a;
        logic [3:0]  tr_cin;

        n_cmp = 0; n_err = 0;
        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_busy", {31'b0, busy4}, 0);
        check("rst_done", {31'b0, done4}, 0);
        check("rst_sum", {16'b0, sum4}, 0);
        check("rst_cout", {31'b0, cout4}, 0);
        check("rst_add_a", {28'b0, add_a4}, 0);
        check("rst_busy2", {31'b0, busy2}, 0);

        // 0x1234 + 0x0FFF
        go4(16'h1234, 16'h0FFF, 1'b0, lat, tr_a, tr_cin);
        check("t1_latency", lat, 5);
        check("t1_sum", {16'b0, sum4}, 32'h2233);
        check("t1_cout", {31'b0, cout4}, 0);
        check("t1_busy_in_done", {31'b0, busy4}, 1);
        check("t1_add_a_trace", {16'b0, tr_a}, 32'h1234);
        check("t1_cin_trace", {28'b0, tr_cin}, 32'b1110);
        check("t1_add_a_done", {28'b0, add_a4}, 0);
        @(negedge clk);
        check("t1_busy_after", {31'b0, busy4}, 0);
        check("t1_done_after", {31'b0, done4}, 0);
        check("t1_sum_hold", {16'b0, sum4}, 32'h2233);

        // Full ripple across all nibbles
        go4(16'hFFFF, 16'h0001, 1'b0, lat, tr_a, tr_cin);
        check("t2_latency", lat, 5);
        check("t2_sum", {16'b0, sum4}, 32'h0000);
        check("t2_cout", {31'b0, cout4}, 1);
        check("t2_cin_trace", {28'b0, tr_cin}, 32'b1110);

        // Carry-in on nibble 0
        go4(16'hFFFF, 16'hFFFF, 1'b1, lat, tr_a, tr_cin);
        check("t3_sum", {16'b0, sum4}, 32'hFFFF);
        check("t3_cout", {31'b0, cout4}, 1);
        check("t3_cin_trace", {28'b0, tr_cin}, 32'b1111);
        @(negedge clk);

        // Start during RUN and during DONE is ignored
        a4 = 16'h0001; b4 = 16'h0001; cin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        a4 = 16'hAAAA; b4 = 16'h5555; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        n_done = 0;
        lat = 0;
        while (!done4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (done4) n_done++;
        check("busy_sum", {16'b0, sum4}, 32'h0002);
        check("busy_cout", {31'b0, cout4}, 0);
        a4 = 16'h0F00; b4 = 16'h0000; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check("busy_start_in_done", {31'b0, busy4}, 0);
        for (int i = 0; i < 6; i++) begin
            if (done4) n_done++;
            @(negedge clk);
        end
        check("busy_done_pulses", n_done, 1);
        check("busy_sum_hold", {16'b0, sum4}, 32'h0002);

        // Reset two cycles into RUN
        a4 = 16'h1111; b4 = 16'h2222; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", {31'b0, busy4}, 0);
        check("mid_rst_done", {31'b0, done4}, 0);
        check("mid_rst_sum", {16'b0, sum4}, 0);
        check("mid_rst_cout", {31'b0, cout4}, 0);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            if (done4) n_done++;
            @(negedge clk);
        end
        check("mid_rst_no_done", n_done, 0);
        go4(16'h0010, 16'h0020, 1'b0, lat, tr_a, tr_cin);
        check("post_rst_latency", lat, 5);
        check("post_rst_sum", {16'b0, sum4}, 32'h0030);
        @(negedge clk);

        // rst and start on the same edge: reset wins
        a4 = 16'h0005; b4 = 16'h0005; rst = 1'b1; start4 = 1'b1;
        @(negedge clk);
        rst = 1'b0; start4 = 1'b0;
        check("rst_start_busy", {31'b0, busy4}, 0);
        check("rst_start_sum", {16'b0, sum4}, 0);

        // NIBBLES=2
        a2 = 8'hAB; b2 = 8'h55; cin2 = 1'b0; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 1;
        while (!done2 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("n2_latency", lat, 3);
        check("n2_sum", {24'b0, sum2}, 32'h00);
        check("n2_cout", {31'b0, cout2}, 1);
        @(negedge clk);
        check("n2_busy_after", {31'b0, busy2}, 0);
        a2 = 8'h3C; b2 = 8'h12; cin2 = 1'b1; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 1;
        while (!done2 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("n2b_latency", lat, 3);
        check("n2b_sum", {24'b0, sum2}, 32'h4F);
        check("n2b_cout", {31'b0, cout2}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
